cnn_conv_layer_sequencer: RTL and testbench
===========================================

CNN_CONV_LAYER_SEQUENCER -- requirements
Module: cnn_conv_layer_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the pixel and weight word width.
REQ-002 SHALL have parameters IMAGE_WIDTH / IMAGE_HEIGHT, default 32 / 32, the input feature-map size.
REQ-003 SHALL have parameters CHANNEL_NUM_IN / CHANNEL_NUM_OUT / KERNEL, default 4 / 1 / 3, the conv geometry.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, the drain watchdog limit.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock; one clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle layer launch request.
- stride2_cfg  in  1  stride-2 select, sampled at start.
- busy  out  1  layer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.
- wgt_rd_en / wgt_rd_addr / wgt_rd_data  out 1 / out clog2(WEIGHT_NUM) / in DATA_WIDTH  weight memory port, 1-cycle read latency.
- pxl_rd_en / pxl_rd_addr / pxl_rd_data  out 1 / out clog2(PIXEL_NUM) / in DATA_WIDTH  pixel memory port, 1-cycle read latency.
- conv_valid_weight_in / conv_weight_in  out 1 / out DATA_WIDTH  weight stream to the conv engine.
- conv_valid_in / conv_pxl_in / conv_stride2  out 1 / out DATA_WIDTH / out 1  pixel stream and stride to the conv engine.
- conv_valid_out / conv_pxl_out  in 1 / in DATA_WIDTH  conv engine result.
- out_valid / out_data / out_last  out 1 / out DATA_WIDTH / out 1  forwarded result stream.

Function
REQ-006 SHALL derive WEIGHT_NUM = CHANNEL_NUM_IN*CHANNEL_NUM_OUT*KERNEL*KERNEL and PIXEL_NUM = CHANNEL_NUM_IN*IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-007 SHALL derive the expected output count: CHANNEL_NUM_OUT*W*H when stride2 = 0, or CHANNEL_NUM_OUT*(W/2)*(H/2) when stride2 = 1.
REQ-008 SHALL implement FSM states IDLE, LOAD_W, STREAM_PX, DRAIN and DONE.
REQ-009 SHALL, on start in IDLE, latch stride2_cfg into conv_stride2 and enter LOAD_W on the next cycle.
REQ-010 SHALL, in LOAD_W, assert wgt_rd_en every cycle with addresses 0..WEIGHT_NUM-1 ascending.
REQ-011 SHALL, on the cycle after issuing the last weight address, enter STREAM_PX.
REQ-012 SHALL, in STREAM_PX, assert pxl_rd_en every cycle with addresses 0..PIXEL_NUM-1 ascending, then enter DRAIN.
REQ-013 SHALL drive conv_valid_weight_in and conv_valid_in as rd_en delayed by one cycle, with conv_weight_in = wgt_rd_data and conv_pxl_in = pxl_rd_data.
REQ-014 SHALL forward conv_pxl_out to out_data with out_valid = conv_valid_out, one-cycle registered latency, while busy.
REQ-015 SHALL assert out_last with the final expected output.
REQ-016 SHALL drop conv_valid_out beats beyond the expected count or while in IDLE.
REQ-017 SHALL count outputs from LOAD_W onward; when the count reaches the expected value it SHALL enter DONE.
REQ-018 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-019 SHALL hold busy = 1 in every state except IDLE.
REQ-020 SHALL ignore start while busy; start on the DONE cycle is also ignored.
REQ-021 SHALL hold conv_stride2 constant from start until return to IDLE.

Reset
REQ-022 SHALL, on reset low, immediately set the FSM to IDLE, clear all counters and drive every output to 0, including mid-layer.
REQ-023 SHALL discard any layer interrupted by reset, with no done or err pulse.

Configuration
REQ-024 SHALL, with CNN_SEQ_TIMEOUT_EN defined, count DRAIN cycles since the last accepted output.
REQ-025 SHALL, with CNN_SEQ_TIMEOUT_EN defined, pulse err and done together and return to IDLE when that count reaches TIMEOUT_CYCLES.
REQ-026 SHALL, without CNN_SEQ_TIMEOUT_EN, compile out the watchdog, tie err to 0 and wait in DRAIN indefinitely.

Structure
REQ-027 SHALL take the FSM state enum and the WEIGHT_NUM, PIXEL_NUM and expected-output count functions from shared package cnn_pkg.
REQ-028 SHALL instantiate one sub-module, cnn_seq_addr_gen, a parameterised ascending address counter with last flag, once for weights and once for pixels.

Verification (W=H=4, CI=2, CO=1, K=3, conv engine behavioural model)
REQ-029 Stride 1: start with stride2_cfg=0 -> 18 weight reads then 32 pixel reads, 16 out_valid beats, out_last on the 16th, done one cycle after the 16th output.
REQ-030 Stride 2: start with stride2_cfg=1 -> conv_stride2=1 throughout, 4 outputs, done after the 4th.
REQ-031 Start while busy: second start pulse during STREAM_PX -> no address restart, exactly one done.
REQ-032 Reset mid-layer: reset low during LOAD_W at address 7 -> all outputs 0 next cycle; a fresh start restarts weight reads at address 0.
REQ-033 Timeout (CNN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): model stops after 10 outputs -> err and done pulse together 16 cycles after the 10th output; busy falls.
REQ-034 Extra outputs: model emits 17 beats -> only 16 forwarded, the 17th dropped, out_last on the 16th only.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN conv-layer sequencer: FSM state encoding and
// geometry helpers for weight, pixel and expected-output counts.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM_PX,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  function automatic int weight_num(input int ch_in, input int ch_out, input int kernel);
    return ch_in * ch_out * kernel * kernel;
  endfunction

  function automatic int pixel_num(input int ch_in, input int width, input int height);
    return ch_in * width * height;
  endfunction

  function automatic int expected_outputs(input int ch_out, input int width, input int height,
                                          input bit stride2);
    return stride2 ? ch_out * (width / 2) * (height / 2) : ch_out * width * height;
  endfunction

endpackage

// File: rtl/cnn_seq_addr_gen.sv
// Ascending read-address counter 0..COUNT-1 with a last-address flag; wraps to 0
// after the last address and is held at 0 by clear.
module cnn_seq_addr_gen #(
  parameter int COUNT = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] addr,
  output logic             last
);

  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(COUNT - 1);

  assign last = (addr == LAST_ADDR);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      addr <= '0;
    else if (clear)  addr <= '0;
    else if (en)     addr <= last ? '0 : addr + 1'b1;
  end

endmodule

// File: rtl/cnn_conv_layer_sequencer.sv
// Conv-layer sequencer: loads weights, streams pixels, forwards engine results.
// Optional drain watchdog enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_conv_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int  DATA_WIDTH      = 32,
  parameter int  IMAGE_WIDTH     = 32,
  parameter int  IMAGE_HEIGHT    = 32,
  parameter int  CHANNEL_NUM_IN  = 4,
  parameter int  CHANNEL_NUM_OUT = 1,
  parameter int  KERNEL          = 3,
  parameter int  TIMEOUT_CYCLES  = 4096,
  localparam int WEIGHT_NUM      = weight_num(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL),
  localparam int PIXEL_NUM       = pixel_num(CHANNEL_NUM_IN, IMAGE_WIDTH, IMAGE_HEIGHT),
  localparam int W_AW            = $clog2(WEIGHT_NUM),
  localparam int P_AW            = $clog2(PIXEL_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stride2_cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  wgt_rd_en,
  output logic [W_AW-1:0]       wgt_rd_addr,
  input  logic [DATA_WIDTH-1:0] wgt_rd_data,
  output logic                  pxl_rd_en,
  output logic [P_AW-1:0]       pxl_rd_addr,
  input  logic [DATA_WIDTH-1:0] pxl_rd_data,
  output logic                  conv_valid_weight_in,
  output logic [DATA_WIDTH-1:0] conv_weight_in,
  output logic                  conv_valid_in,
  output logic [DATA_WIDTH-1:0] conv_pxl_in,
  output logic                  conv_stride2,
  input  logic                  conv_valid_out,
  input  logic [DATA_WIDTH-1:0] conv_pxl_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic [31:0] EXP_S1 =
    32'(expected_outputs(CHANNEL_NUM_OUT, IMAGE_WIDTH, IMAGE_HEIGHT, 1'b0));
  localparam logic [31:0] EXP_S2 =
    32'(expected_outputs(CHANNEL_NUM_OUT, IMAGE_WIDTH, IMAGE_HEIGHT, 1'b1));

  seq_state_t  state, next_state;
  logic        wgt_last, pxl_last;
  logic [31:0] out_cnt, exp_cnt;
  logic        accept, count_hit, timeout_fire;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign wgt_rd_en = (state == S_LOAD_W);
  assign pxl_rd_en = (state == S_STREAM_PX);
  assign exp_cnt   = conv_stride2 ? EXP_S2 : EXP_S1;
  assign count_hit = (out_cnt == exp_cnt);

  // Results are taken only in the active states and only up to the expected count.
  assign accept = conv_valid_out && !count_hit &&
                  (state inside {S_LOAD_W, S_STREAM_PX, S_DRAIN});

  // Read data is gated so the engine inputs stay 0 outside valid beats.
  assign conv_weight_in = conv_valid_weight_in ? wgt_rd_data : '0;
  assign conv_pxl_in    = conv_valid_in ? pxl_rd_data : '0;

  cnn_seq_addr_gen #(.COUNT(WEIGHT_NUM), .WIDTH(W_AW)) u_wgt_addr (
    .clk(clk), .reset(reset), .clear(state == S_IDLE), .en(wgt_rd_en),
    .addr(wgt_rd_addr), .last(wgt_last)
  );

  cnn_seq_addr_gen #(.COUNT(PIXEL_NUM), .WIDTH(P_AW)) u_pxl_addr (
    .clk(clk), .reset(reset), .clear(state == S_IDLE), .en(pxl_rd_en),
    .addr(pxl_rd_addr), .last(pxl_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:      if (start) next_state = S_LOAD_W;
      S_LOAD_W:    if (count_hit) next_state = S_DONE;
                   else if (wgt_last) next_state = S_STREAM_PX;
      S_STREAM_PX: if (count_hit) next_state = S_DONE;
                   else if (pxl_last) next_state = S_DRAIN;
      S_DRAIN:     if (count_hit || timeout_fire) next_state = S_DONE;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_stride2         <= 1'b0;
      conv_valid_weight_in <= 1'b0;
      conv_valid_in        <= 1'b0;
      out_cnt              <= '0;
      out_valid            <= 1'b0;
      out_data             <= '0;
      out_last             <= 1'b0;
    end else begin
      if (state == S_IDLE && start) conv_stride2 <= stride2_cfg;
      conv_valid_weight_in <= wgt_rd_en;
      conv_valid_in        <= pxl_rd_en;
      if (state == S_IDLE) out_cnt <= '0;
      else if (accept)     out_cnt <= out_cnt + 1'b1;
      out_valid <= accept;
      out_data  <= accept ? conv_pxl_out : '0;
      out_last  <= accept && (out_cnt == exp_cnt - 1'b1);
    end
  end

`ifdef CNN_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timed_out;

  // Idle DRAIN cycles since the last accepted result.
  assign timeout_fire = (state == S_DRAIN) && !accept && !count_hit &&
                        (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign err = done && timed_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state != S_DRAIN || accept) wd_cnt <= '0;
      else                            wd_cnt <= wd_cnt + 1'b1;
      if (timeout_fire)        timed_out <= 1'b1;
      else if (state == S_DONE) timed_out <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_fire   = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_conv_layer_sequencer.sv
// Directed bench for cnn_conv_layer_sequencer (W=H=4, CI=2, CO=1, K=3) with
// memory and conv-engine models; timeout case built when CNN_SEQ_TIMEOUT_EN is defined.
module tb_cnn_conv_layer_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stride2_cfg = 1'b0;
  logic          busy, done, err;
  logic          wgt_rd_en, pxl_rd_en;
  logic [4:0]    wgt_rd_addr, pxl_rd_addr;
  logic [DW-1:0] wgt_rd_data = '0, pxl_rd_data = '0;
  logic          conv_valid_weight_in, conv_valid_in, conv_stride2;
  logic [DW-1:0] conv_weight_in, conv_pxl_in;
  logic          conv_valid_out = 1'b0;
  logic [DW-1:0] conv_pxl_out = '0;
  logic          out_valid, out_last;
  logic [DW-1:0] out_data;

  cnn_conv_layer_sequencer #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(1), .KERNEL(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stride2_cfg(stride2_cfg),
    .busy(busy), .done(done), .err(err),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .pxl_rd_en(pxl_rd_en), .pxl_rd_addr(pxl_rd_addr), .pxl_rd_data(pxl_rd_data),
    .conv_valid_weight_in(conv_valid_weight_in), .conv_weight_in(conv_weight_in),
    .conv_valid_in(conv_valid_in), .conv_pxl_in(conv_pxl_in), .conv_stride2(conv_stride2),
    .conv_valid_out(conv_valid_out), .conv_pxl_out(conv_pxl_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Memories with one-cycle read latency; idle data is junk to expose missing gating.
  always @(posedge clk) begin
    wgt_rd_data <= wgt_rd_en ? DW'(100 + int'(wgt_rd_addr)) : 32'hdead_beef;
    pxl_rd_data <= pxl_rd_en ? DW'(1000 + int'(pxl_rd_addr)) : 32'hdead_beef;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor, sampled on the falling edge.
  logic mon_rst = 1'b0;
  logic exp_stride = 1'b0;
  int cyc = 0;
  int w_reads, w_bad, p_reads, p_bad, cw_n, cw_bad, cp_n, cp_bad;
  int out_n, data_bad, last_cnt, last_idx, last_out_cyc;
  int done_cnt, done_cyc, err_cnt, err_with_done, stride_bad;

  always @(negedge clk) begin
    cyc++;
    if (mon_rst) begin
      w_reads = 0; w_bad = 0; p_reads = 0; p_bad = 0;
      cw_n = 0; cw_bad = 0; cp_n = 0; cp_bad = 0;
      out_n = 0; data_bad = 0; last_cnt = 0; last_idx = 0; last_out_cyc = 0;
      done_cnt = 0; done_cyc = 0; err_cnt = 0; err_with_done = 0; stride_bad = 0;
    end else begin
      if (wgt_rd_en) begin
        if (int'(wgt_rd_addr) != w_reads) w_bad++;
        w_reads++;
      end
      if (pxl_rd_en) begin
        if (int'(pxl_rd_addr) != p_reads) p_bad++;
        p_reads++;
      end
      if (conv_valid_weight_in) begin
        if (conv_weight_in != DW'(100 + cw_n)) cw_bad++;
        cw_n++;
      end
      if (conv_valid_in) begin
        if (conv_pxl_in != DW'(1000 + cp_n)) cp_bad++;
        cp_n++;
      end
      if (out_valid) begin
        if (out_data != DW'(5000 + out_n)) data_bad++;
        out_n++;
        last_out_cyc = cyc;
        if (out_last) last_idx = out_n;
      end
      if (out_last) last_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (err) err_with_done++;
      end
      if (err) err_cnt++;
      if (busy && conv_stride2 != exp_stride) stride_bad++;
    end
  end

  task automatic clear_mon();
    @(posedge clk); mon_rst = 1'b1;
    @(posedge clk); mon_rst = 1'b0;
  endtask

  // One layer: start, wait for the pixel stream, emit `beats` engine results, wait for done.
  task automatic run_layer(input string tag, input bit s2, input int beats, input bit dbl_start);
    bit seen;
    exp_stride = s2;
    clear_mon();
    @(negedge clk); #1;
    start = 1'b1; stride2_cfg = s2;
    @(negedge clk); #1;
    start = 1'b0; stride2_cfg = ~s2;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (dbl_start) start = (p_reads == 5);
      seen = (cp_n == 32);
    end
    start = 1'b0;
    check({tag, "_pixel_wait"}, 64'(seen), 64'd1);
    for (int i = 0; i < beats; i++) begin
      conv_valid_out = 1'b1;
      conv_pxl_out   = DW'(5000 + i);
      @(negedge clk); #1;
    end
    conv_valid_out = 1'b0;
    conv_pxl_out   = '0;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_w_reads"}, 64'(w_reads), 64'd18);
    check({tag, "_w_addr"}, 64'(w_bad), 64'd0);
    check({tag, "_p_reads"}, 64'(p_reads), 64'd32);
    check({tag, "_p_addr"}, 64'(p_bad), 64'd0);
    check({tag, "_conv_w"}, 64'(cw_n * 100 + cw_bad), 64'd1800);
    check({tag, "_conv_px"}, 64'(cp_n * 100 + cp_bad), 64'd3200);
  endtask

  initial begin
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs_zero", 64'(|{done, err, wgt_rd_en, wgt_rd_addr, pxl_rd_en, pxl_rd_addr,
                                  conv_valid_weight_in, conv_weight_in, conv_valid_in,
                                  conv_pxl_in, conv_stride2, out_valid, out_data, out_last}),
          64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Stride 1: 16 outputs, last on the 16th, done one cycle after it.
    run_layer("s1", 1'b0, 16, 1'b0);
    check_reads("s1");
    check("s1_out_n", 64'(out_n), 64'd16);
    check("s1_data", 64'(data_bad), 64'd0);
    check("s1_last_cnt", 64'(last_cnt), 64'd1);
    check("s1_last_idx", 64'(last_idx), 64'd16);
    check("s1_done_cnt", 64'(done_cnt), 64'd1);
    check("s1_done_lat", 64'(done_cyc - last_out_cyc), 64'd1);
    check("s1_err", 64'(err_cnt), 64'd0);
    check("s1_stride", 64'(stride_bad), 64'd0);
    check("s1_idle", 64'(busy), 64'd0);

    // Stride 2: 4 outputs, conv_stride2 held high throughout.
    run_layer("s2", 1'b1, 4, 1'b0);
    check("s2_out_n", 64'(out_n), 64'd4);
    check("s2_last_idx", 64'(last_idx), 64'd4);
    check("s2_done_cnt", 64'(done_cnt), 64'd1);
    check("s2_done_lat", 64'(done_cyc - last_out_cyc), 64'd1);
    check("s2_stride", 64'(stride_bad), 64'd0);

    // Second start during the pixel stream is ignored.
    run_layer("dbl", 1'b0, 16, 1'b1);
    check_reads("dbl");
    check("dbl_done_cnt", 64'(done_cnt), 64'd1);

    // Extra engine beat beyond the expected count is dropped.
    run_layer("xtra", 1'b0, 17, 1'b0);
    check("xtra_out_n", 64'(out_n), 64'd16);
    check("xtra_data", 64'(data_bad), 64'd0);
    check("xtra_last_cnt", 64'(last_cnt), 64'd1);
    check("xtra_last_idx", 64'(last_idx), 64'd16);
    check("xtra_done_cnt", 64'(done_cnt), 64'd1);

    // Reset asserted while weight address 7 is being read.
    begin
      bit hit;
      exp_stride = 1'b1;
      clear_mon();
      @(negedge clk); #1;
      start = 1'b1; stride2_cfg = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
        hit = wgt_rd_en && (wgt_rd_addr == 5'd7);
        if (!hit) begin
          @(negedge clk); #1;
        end
      end
      check("mid_rst_reach_a7", 64'(hit), 64'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_outs_zero", 64'(|{done, err, wgt_rd_en, wgt_rd_addr, pxl_rd_en, pxl_rd_addr,
                                       conv_valid_weight_in, conv_weight_in, conv_valid_in,
                                       conv_pxl_in, conv_stride2, out_valid, out_data,
                                       out_last}), 64'd0);
      repeat (3) @(negedge clk);
      check("mid_rst_no_done", 64'(done_cnt + err_cnt), 64'd0);
      reset = 1'b1;
    end
    run_layer("post_rst", 1'b0, 16, 1'b0);
    check_reads("post_rst");
    check("post_rst_done", 64'(done_cnt), 64'd1);

`ifdef CNN_SEQ_TIMEOUT_EN
    // Engine stalls after 10 results: err and done pulse 16 cycles later.
    run_layer("tmo", 1'b0, 10, 1'b0);
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    check("tmo_out_n", 64'(out_n), 64'd10);
    check("tmo_done_cnt", 64'(done_cnt), 64'd1);
    check("tmo_err_cnt", 64'(err_cnt), 64'd1);
    check("tmo_err_with_done", 64'(err_with_done), 64'd1);
    check("tmo_lat", 64'(done_cyc - last_out_cyc), 64'd16);
    check("tmo_idle", 64'(busy), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
